// File: rtl/clap_command_controller.sv
// Clap-count command controller: accepts one count, decodes it into a lamp command,
// then holds off further counts for a lockout window. Owns the lamp state and auto-off timer.
module clap_command_controller #(
  parameter int unsigned SUC_CLAPS_WIDTH = 16,
  parameter int unsigned TOGGLE_CLAPS    = 2,
  parameter int unsigned TIMER_CLAPS     = 3,
  parameter int unsigned OFF_CLAPS       = 4,
  parameter int unsigned TIMER_CYCLES    = 50000000,
  parameter int unsigned LOCKOUT_CYCLES  = 5000000
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
  input  logic                       suc_claps_valid,
  output logic                       suc_claps_ready,
  output logic                       light_on,
  output logic                       timer_active,
  output logic                       cmd_event,
  output logic [1:0]                 cmd_code
);

  localparam int unsigned TIMER_W = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
  localparam int unsigned LOCK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [1:0] CODE_NONE   = 2'd0;
  localparam logic [1:0] CODE_TOGGLE = 2'd1;
  localparam logic [1:0] CODE_TIMED  = 2'd2;
  localparam logic [1:0] CODE_OFF    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t                     state;
  logic [SUC_CLAPS_WIDTH-1:0] count_q;
  logic                       decoded;
  logic [1:0]                 match_q;
  logic [TIMER_W-1:0]         timer_cnt;
  logic [LOCK_W-1:0]          lock_cnt;
  logic [1:0]                 match_c;

  // Full-width compare of the captured count; toggle wins over timer wins over off.
  always_comb begin
    match_c = CODE_NONE;
    if (count_q == SUC_CLAPS_WIDTH'(TOGGLE_CLAPS)) begin
      match_c = CODE_TOGGLE;
    end else if (count_q == SUC_CLAPS_WIDTH'(TIMER_CLAPS)) begin
      match_c = CODE_TIMED;
    end else if (count_q == SUC_CLAPS_WIDTH'(OFF_CLAPS)) begin
      match_c = CODE_OFF;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state           <= IDLE;
      count_q         <= '0;
      decoded         <= 1'b0;
      match_q         <= CODE_NONE;
      timer_cnt       <= '0;
      lock_cnt        <= '0;
      suc_claps_ready <= 1'b0;
      light_on        <= 1'b0;
      timer_active    <= 1'b0;
      cmd_event       <= 1'b0;
      cmd_code        <= CODE_NONE;
    end else begin
      cmd_event <= 1'b0;

      // Auto-off timer runs independently; a decode on the same edge overrides it below.
      if (timer_active) begin
        if (timer_cnt == '0) begin
          light_on     <= 1'b0;
          timer_active <= 1'b0;
        end else begin
          timer_cnt <= timer_cnt - TIMER_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (suc_claps_valid && suc_claps_ready) begin
            count_q         <= suc_claps_data;
            suc_claps_ready <= 1'b0;
            decoded         <= 1'b0;
            state           <= DECODE;
          end else begin
            suc_claps_ready <= 1'b1;
          end
        end

        // First DECODE edge registers the match, second one executes it.
        DECODE: begin
          if (!decoded) begin
            match_q <= match_c;
            decoded <= 1'b1;
          end else begin
            decoded  <= 1'b0;
            cmd_code <= match_q;
            case (match_q)
              CODE_TOGGLE: begin
                light_on     <= ~light_on;
                timer_active <= 1'b0;
              end
              CODE_TIMED: begin
                light_on     <= 1'b1;
                timer_active <= 1'b1;
                timer_cnt    <= TIMER_W'(TIMER_CYCLES - 1);
              end
              CODE_OFF: begin
                light_on     <= 1'b0;
                timer_active <= 1'b0;
              end
              default: begin
              end
            endcase
            if (match_q != CODE_NONE) begin
              cmd_event <= 1'b1;
              lock_cnt  <= LOCK_W'(LOCKOUT_CYCLES - 1);
              state     <= LOCKOUT;
            end else begin
              suc_claps_ready <= 1'b1;
              state           <= IDLE;
            end
          end
        end

        LOCKOUT: begin
          if (lock_cnt == '0) begin
            suc_claps_ready <= 1'b1;
            state           <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
          end
        end

        default: begin
          suc_claps_ready <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
